arrow_scheduler: RTL and testbench

//  Owns a pool of on-screen arrow sprites for the four lanes: accepts spawn requests,

---
 rtl/stepmania_pkg.sv | 32 +++
 rtl/arrow_slot.sv | 70 +++++++
 rtl/arrow_scheduler.sv | 127 ++++++++++++
 tb/tb_arrow_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stepmania_pkg.sv
// Shared types and constants for the arrow sprite pool and its lane geometry.
package stepmania_pkg;

   typedef enum logic [1:0] {
      LANE_L = 2'd0,
      LANE_D = 2'd1,
      LANE_U = 2'd2,
      LANE_R = 2'd3
   } lane_t;

   typedef struct packed {
      logic       live;
      lane_t      lane;
      logic [9:0] y_pos;
   } arrow_slot_t;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned COORD_W  = 10;
   localparam int unsigned NUM_LANES = 4;

   localparam logic [0:0] SLOT_FREE = 1'b0;
   localparam logic [0:0] SLOT_LIVE = 1'b1;

   // Left edge of a lane's sprite column.
   function automatic logic [COORD_W-1:0] lane_x(input lane_t lane,
                                                  input logic [COORD_W-1:0] x0,
                                                  input logic [COORD_W-1:0] pitch);
      return x0 + COORD_W'(COORD_W'(lane) * pitch);
   endfunction

endpackage

// File: rtl/arrow_slot.sv
// One arrow sprite slot: load on spawn, scroll/retire on frame tick, pixel hit test.
module arrow_slot
   import stepmania_pkg::*;
#(
   parameter logic [9:0] SPAWN_Y     = 10'(SCREEN_H),
   parameter logic [9:0] SCROLL_STEP = 10'd4,
   parameter logic [9:0] LANE_X0     = 10'd192,
   parameter logic [9:0] LANE_PITCH  = 10'd64,
   parameter logic [9:0] ARROW_SIZE  = 10'd32
) (
   input  logic       Clk,
   input  logic       i_clear,
   input  logic       i_tick,
   input  logic       i_load,
   input  lane_t      i_lane,
   input  logic [9:0] i_draw_x,
   input  logic [9:0] i_draw_y,
   output logic       o_live,
   output lane_t      o_lane,
   output logic       o_retire_c,
   output logic       o_hit_c
);

   arrow_slot_t r_slot;
   arrow_slot_t w_slot_nxt;
   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic [9:0]  w_dx;
   logic [9:0]  w_dy;

   always_ff @(posedge Clk) begin
      if (i_clear) begin
         r_state <= SLOT_FREE;
         r_slot  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
      end
   end

   // A slot that is free at the start of the cycle never sees the tick.
   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      o_retire_c  = 1'b0;
      if (r_state == SLOT_FREE) begin
         if (i_load) begin
            w_state_nxt      = SLOT_LIVE;
            w_slot_nxt.lane  = i_lane;
            w_slot_nxt.y_pos = SPAWN_Y;
         end
      end else if (i_tick) begin
         if (r_slot.y_pos < SCROLL_STEP) begin
            w_state_nxt = SLOT_FREE;
            o_retire_c  = ~i_clear;
         end else begin
            w_slot_nxt.y_pos = r_slot.y_pos - SCROLL_STEP;
         end
      end
      w_slot_nxt.live = (w_state_nxt == SLOT_LIVE);
   end

   // Unsigned wrap turns pixels left of / above the sprite into large misses.
   assign w_dx    = i_draw_x - lane_x(r_slot.lane, LANE_X0, LANE_PITCH);
   assign w_dy    = i_draw_y - r_slot.y_pos;
   assign o_hit_c = (r_state == SLOT_LIVE) && (w_dx < ARROW_SIZE) && (w_dy < ARROW_SIZE);
   assign o_live  = (r_state == SLOT_LIVE) && r_slot.live;
   assign o_lane  = r_slot.lane;

endmodule

// File: rtl/arrow_scheduler.sv
// Arrow sprite pool: spawn allocation, per-frame scroll, per-lane draw mask.
// Optional ARROW_MISS_COUNT_EN adds a saturating count of arrows scrolled off the top.
module arrow_scheduler
   import stepmania_pkg::*;
#(
   parameter int unsigned NUM_SLOTS   = 8,
   parameter logic [9:0]  SPAWN_Y     = 10'(SCREEN_H),
   parameter logic [9:0]  SCROLL_STEP = 10'd4,
   parameter logic [9:0]  LANE_X0     = 10'd192,
   parameter logic [9:0]  LANE_PITCH  = 10'd64,
   parameter logic [9:0]  ARROW_SIZE  = 10'd32
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       frame_clk,
   input  logic       flush,
   input  logic       spawn_valid,
   input  logic [1:0] spawn_lane,
   output logic       spawn_ready,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic [3:0] display_arrow,
`ifdef ARROW_MISS_COUNT_EN
   output logic [7:0] miss_count,
`endif
   output logic [4:0] active_count
);

   localparam int unsigned CNT_W = 5;

   logic                 r_frame_clk_q;
   logic                 w_tick;
   logic                 w_clear;
   logic                 w_accept;
   logic                 w_found;
   logic [NUM_SLOTS-1:0] w_live;
   logic [NUM_SLOTS-1:0] w_hit;
   logic [NUM_SLOTS-1:0] w_retire;
   logic [NUM_SLOTS-1:0] w_load;
   lane_t                w_lane [NUM_SLOTS];
   logic [CNT_W-1:0]     w_retire_cnt;
   logic [NUM_LANES-1:0] w_disp;
   logic [NUM_LANES-1:0] r_display;
   logic [CNT_W-1:0]     r_count;

   assign w_clear     = reset | flush;
   assign w_tick      = frame_clk & ~r_frame_clk_q;
   assign spawn_ready = ~&w_live;
   assign w_accept    = spawn_valid & spawn_ready;

   always_ff @(posedge Clk) begin
      if (reset) r_frame_clk_q <= 1'b0;
      else       r_frame_clk_q <= frame_clk;
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      arrow_slot #(
         .SPAWN_Y     (SPAWN_Y),
         .SCROLL_STEP (SCROLL_STEP),
         .LANE_X0     (LANE_X0),
         .LANE_PITCH  (LANE_PITCH),
         .ARROW_SIZE  (ARROW_SIZE)
      ) u_slot (
         .Clk        (Clk),
         .i_clear    (w_clear),
         .i_tick     (w_tick),
         .i_load     (w_load[g]),
         .i_lane     (lane_t'(spawn_lane)),
         .i_draw_x   (DrawX),
         .i_draw_y   (DrawY),
         .o_live     (w_live[g]),
         .o_lane     (w_lane[g]),
         .o_retire_c (w_retire[g]),
         .o_hit_c    (w_hit[g])
      );
   end

   // Lowest-index free slot takes the accepted spawn.
   always_comb begin
      w_load  = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!w_live[i] && !w_found) begin
            w_load[i] = w_accept;
            w_found   = 1'b1;
         end
      end
   end

   always_comb begin
      w_disp       = '0;
      w_retire_cnt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (w_hit[i]) w_disp[w_lane[i]] = 1'b1;
         w_retire_cnt = w_retire_cnt + CNT_W'(w_retire[i]);
      end
   end

   always_ff @(posedge Clk) begin
      if (w_clear) begin
         r_display <= '0;
         r_count   <= '0;
      end else begin
         r_display <= w_disp;
         r_count   <= CNT_W'(r_count + CNT_W'(w_accept) - w_retire_cnt);
      end
   end

   assign display_arrow = r_display;
   assign active_count  = r_count;

`ifdef ARROW_MISS_COUNT_EN
   logic [7:0] r_miss;
   logic [8:0] w_miss_sum;

   assign w_miss_sum = 9'(r_miss) + 9'(w_retire_cnt);

   always_ff @(posedge Clk) begin
      if (w_clear)               r_miss <= '0;
      else if (w_miss_sum[8])    r_miss <= 8'hFF;
      else                       r_miss <= w_miss_sum[7:0];
   end

   assign miss_count = r_miss;
`endif

endmodule

// File: tb/tb_arrow_scheduler.sv
// Self-checking bench for arrow_scheduler: directed scenarios plus randomized traffic vs a slot-pool model.
module tb_arrow_scheduler;

   localparam int NS    = 8;
   localparam int SPY   = 480;
   localparam int STEP  = 4;
   localparam int X0    = 192;
   localparam int PITCH = 64;
   localparam int SZ    = 32;

   logic       Clk = 1'b0;
   logic       reset, frame_clk, flush, spawn_valid, spawn_ready;
   logic [1:0] spawn_lane;
   logic [9:0] DrawX, DrawY;
   logic [3:0] display_arrow;
   logic [4:0] active_count;
`ifdef ARROW_MISS_COUNT_EN
   logic [7:0] miss_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference pool
   bit m_live [NS];
   int m_lane [NS];
   int m_y    [NS];
   int m_miss;
   bit m_fq;

   always #5 Clk = ~Clk;

   arrow_scheduler dut (
      .Clk           (Clk),
      .reset         (reset),
      .frame_clk     (frame_clk),
      .flush         (flush),
      .spawn_valid   (spawn_valid),
      .spawn_lane    (spawn_lane),
      .spawn_ready   (spawn_ready),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .display_arrow (display_arrow),
`ifdef ARROW_MISS_COUNT_EN
      .miss_count    (miss_count),
`endif
      .active_count  (active_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < NS; i++) if (m_live[i]) c++;
      return c;
   endfunction

   // One clock: drive at negedge, check comb ready, step model, check registered outputs after posedge.
   task automatic cyc(input bit rst, input bit fl, input bit sv, input int ln,
                      input bit fc, input int dx, input int dy);
      int  first;
      bit  tick;
      int  disp_exp;
      reset = rst; flush = fl; spawn_valid = sv; spawn_lane = 2'(ln);
      frame_clk = fc; DrawX = 10'(dx); DrawY = 10'(dy);
      #1;
      first = -1;
      for (int i = 0; i < NS; i++) if (!m_live[i] && first < 0) first = i;
      if (!rst) check_eq("spawn_ready", {31'd0, spawn_ready}, {31'd0, first >= 0});
      disp_exp = 0;
      for (int i = 0; i < NS; i++) begin
         int xl = X0 + m_lane[i] * PITCH;
         if (m_live[i] && dx >= xl && dx < xl + SZ && dy >= m_y[i] && dy < m_y[i] + SZ)
            disp_exp |= (1 << m_lane[i]);
      end
      tick = fc && !m_fq;
      m_fq = rst ? 1'b0 : fc;
      if (rst || fl) begin
         for (int i = 0; i < NS; i++) m_live[i] = 1'b0;
         m_miss   = 0;
         disp_exp = 0;
      end else begin
         if (tick) begin
            for (int i = 0; i < NS; i++) begin
               if (m_live[i]) begin
                  if (m_y[i] < STEP) begin
                     m_live[i] = 1'b0;
                     if (m_miss < 255) m_miss++;
                  end else begin
                     m_y[i] -= STEP;
                  end
               end
            end
         end
         if (sv && first >= 0) begin
            m_live[first] = 1'b1;
            m_lane[first] = ln;
            m_y[first]    = SPY;
         end
      end
      @(posedge Clk);
      #1;
      check_eq("active_count", 32'(active_count), 32'(model_count()));
      check_eq("display_arrow", 32'(display_arrow), 32'(disp_exp));
`ifdef ARROW_MISS_COUNT_EN
      check_eq("miss_count", 32'(miss_count), 32'(m_miss));
`endif
      @(negedge Clk);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(0, 0, 0, 0, 1, 0, 0);
         cyc(0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      bit fc;
      for (int i = 0; i < NS; i++) begin m_live[i] = 0; m_lane[i] = 0; m_y[i] = 0; end
      m_miss = 0; m_fq = 0;
      @(negedge Clk);

      // Reset then single spawn in lane U
      do_reset();
      check_eq("reset_count", 32'(active_count), 32'd0);
      check_eq("reset_display", 32'(display_arrow), 32'd0);
      cyc(0, 0, 1, 2, 0, 0, 0);
      check_eq("s1_count", 32'(active_count), 32'd1);
      check_eq("s1_ready", {31'd0, spawn_ready}, 32'd1);

      // Lane 0 arrow scrolled 10 frames, then draw hit and left-edge miss
      do_reset();
      cyc(0, 0, 1, 0, 0, 0, 0);
      ticks(10);
      cyc(0, 0, 0, 0, 0, 200, 450);
      check_eq("s2_hit", 32'(display_arrow), 32'b0001);
      cyc(0, 0, 0, 0, 0, 191, 450);
      check_eq("s2_miss_left", 32'(display_arrow), 32'b0000);
      cyc(0, 0, 0, 0, 0, 223, 471);
      check_eq("s2_corner", 32'(display_arrow), 32'b0001);
      cyc(0, 0, 0, 0, 0, 224, 450);
      check_eq("s2_miss_right", 32'(display_arrow), 32'b0000);

      // Fill the pool; the ninth request is dropped
      do_reset();
      for (int k = 0; k < NS + 1; k++) cyc(0, 0, 1, k % 4, 0, 0, 0);
      check_eq("s3_full_count", 32'(active_count), 32'd8);
      check_eq("s3_full_ready", {31'd0, spawn_ready}, 32'd0);

      // Scroll one arrow off the top
      do_reset();
      cyc(0, 0, 1, 3, 0, 0, 0);
      ticks(121);
      check_eq("s4_retired", 32'(active_count), 32'd0);
`ifdef ARROW_MISS_COUNT_EN
      check_eq("s4_miss", 32'(miss_count), 32'd1);
`endif

      // Spawn on the tick cycle: old arrow scrolls, new one stays at spawn row
      do_reset();
      cyc(0, 0, 1, 1, 0, 0, 0);
      ticks(95);
      cyc(0, 0, 1, 3, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 261, 96);
      check_eq("s5_old_top", 32'(display_arrow), 32'b0010);
      cyc(0, 0, 0, 0, 0, 261, 95);
      check_eq("s5_old_above", 32'(display_arrow), 32'b0000);
      cyc(0, 0, 0, 0, 0, 389, 480);
      check_eq("s5_new_top", 32'(display_arrow), 32'b1000);
      cyc(0, 0, 0, 0, 0, 389, 479);
      check_eq("s5_new_above", 32'(display_arrow), 32'b0000);

      // Flush beats a concurrent spawn
      do_reset();
      for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 200, 490);
      check_eq("s6_flush_count", 32'(active_count), 32'd0);
      check_eq("s6_flush_display", 32'(display_arrow), 32'd0);

      // Randomized traffic
      do_reset();
      fc = 0;
      for (int k = 0; k < 4000; k++) begin
         int dx, dy, s;
         bit sv, fl;
         if ($urandom_range(0, 2) == 0) fc = ~fc;
         sv = ($urandom_range(0, 5) == 0);
         fl = ($urandom_range(0, 299) == 0);
         dx = X0 + PITCH * int'($urandom_range(0, 3)) + int'($urandom_range(0, 40)) - 4;
         s  = int'($urandom_range(0, NS - 1));
         if (m_live[s] && $urandom_range(0, 3) != 0)
            dy = m_y[s] + int'($urandom_range(0, 40)) - 4;
         else
            dy = int'($urandom_range(0, 1023));
         if (dy < 0) dy = 0;
         if (dy > 1023) dy = 1023;
         cyc(0, fl, sv, int'($urandom_range(0, 3)), fc, dx, dy);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
